alu_share_arbiter: RTL and testbench

- Shares one instance of the team's 32-bit ALU (opcodes 2=beq, 3=blt, 4=add, 5=sub, 6=and, 7=or; other opcodes pass ip_0 and never branch) between two requesters, A and B.
- Typical pairing: A = main execute stage, B = branch/address helper.
- A three-state FSM sequences each operation: arbitrate and capture, execute, respond.
- Arbitration is round-robin with valid/ready handshakes on both the request and response sides.

---
 rtl/alu_share_arbiter_if.sv | 47 ++++
 rtl/alu_share_arbiter.sv | 167 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two requesters (A, B) and the shared ALU arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface alu_share_arbiter_if #(
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    logic              a_valid;
    logic              a_ready;
    logic [OP_W-1:0]   a_opcode;
    logic [DATA_W-1:0] a_in0;
    logic [DATA_W-1:0] a_in1;

    logic              b_valid;
    logic              b_ready;
    logic [OP_W-1:0]   b_opcode;
    logic [DATA_W-1:0] b_in0;
    logic [DATA_W-1:0] b_in1;

    logic              a_rsp_valid;
    logic              a_rsp_ready;
    logic              b_rsp_valid;
    logic              b_rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_change_pc;
    logic              busy;
    logic [CNT_W-1:0]  op_count;

    modport slave (
        input  a_valid, a_opcode, a_in0, a_in1,
        input  b_valid, b_opcode, b_in0, b_in1,
        input  a_rsp_ready, b_rsp_ready,
        output a_ready, b_ready,
        output a_rsp_valid, b_rsp_valid,
        output rsp_result, rsp_change_pc, busy, op_count
    );

    modport master (
        output a_valid, a_opcode, a_in0, a_in1,
        output b_valid, b_opcode, b_in0, b_in1,
        output a_rsp_ready, b_rsp_ready,
        input  a_ready, b_ready,
        input  a_rsp_valid, b_rsp_valid,
        input  rsp_result, rsp_change_pc, busy, op_count
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one 32-bit ALU between requesters A and B.
// Each operation walks IDLE (grant + capture) -> EXEC (compute) -> RESP (hold until consumed).
module alu_share_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_BEQ = 3'd2;
    localparam logic [OP_W-1:0] OP_BLT = 3'd3;
    localparam logic [OP_W-1:0] OP_ADD = 3'd4;
    localparam logic [OP_W-1:0] OP_SUB = 3'd5;
    localparam logic [OP_W-1:0] OP_AND = 3'd6;
    localparam logic [OP_W-1:0] OP_OR  = 3'd7;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   in0_q, in0_d;
    logic [DATA_W-1:0]   in1_q, in1_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                cpc_q, cpc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                a_rv_q, a_rv_d;
    logic                b_rv_q, b_rv_d;
    logic                busy_q, busy_d;

    logic                a_ready_c;
    logic                b_ready_c;
    logic                rsp_done_c;
    logic [DATA_W-1:0]   alu_res_c;
    logic                alu_cpc_c;

    // Shared ALU, fed only from the captured operation.
    always_comb begin
        alu_res_c = in0_q;
        alu_cpc_c = 1'b0;
        case (op_q)
            OP_BEQ:  alu_cpc_c = (in0_q == in1_q);
            OP_BLT:  alu_cpc_c = (in0_q < in1_q);
            OP_ADD:  alu_res_c = in0_q + in1_q;
            OP_SUB:  alu_res_c = in0_q - in1_q;
            OP_AND:  alu_res_c = in0_q & in1_q;
            OP_OR:   alu_res_c = in0_q | in1_q;
            default: alu_res_c = in0_q;
        endcase
    end

    assign rsp_done_c = (owner_q == OWN_A) ? bus.a_rsp_ready : bus.b_rsp_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant and datapath next values.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        op_d      = op_q;
        in0_d     = in0_q;
        in1_d     = in1_q;
        res_d     = res_q;
        cpc_d     = cpc_q;
        cnt_d     = cnt_q;
        a_ready_c = 1'b0;
        b_ready_c = 1'b0;

        case (state_q)
            IDLE: begin
                // B wins only when A is idle or A was the last one served.
                if (bus.b_valid && (!bus.a_valid || last_q == OWN_A)) begin
                    b_ready_c = 1'b1;
                    owner_d   = OWN_B;
                    op_d      = bus.b_opcode;
                    in0_d     = bus.b_in0;
                    in1_d     = bus.b_in1;
                    state_d   = EXEC;
                end else if (bus.a_valid) begin
                    a_ready_c = 1'b1;
                    owner_d   = OWN_A;
                    op_d      = bus.a_opcode;
                    in0_d     = bus.a_in0;
                    in1_d     = bus.a_in1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_res_c;
                cpc_d   = alu_cpc_c;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_done_c) begin
                    last_d  = owner_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        a_rv_d = (state_d == RESP) && (owner_d == OWN_A);
        b_rv_d = (state_d == RESP) && (owner_d == OWN_B);
        busy_d = (state_d != IDLE);
    end

    // Captured operation, result and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_A;
            last_q  <= OWN_B;
            op_q    <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
            res_q   <= '0;
            cpc_q   <= 1'b0;
            cnt_q   <= '0;
            a_rv_q  <= 1'b0;
            b_rv_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            op_q    <= op_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            res_q   <= res_d;
            cpc_q   <= cpc_d;
            cnt_q   <= cnt_d;
            a_rv_q  <= a_rv_d;
            b_rv_q  <= b_rv_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.a_ready       = a_ready_c;
    assign bus.b_ready       = b_ready_c;
    assign bus.a_rsp_valid   = a_rv_q;
    assign bus.b_rsp_valid   = b_rv_q;
    assign bus.rsp_result    = res_q;
    assign bus.rsp_change_pc = cpc_q;
    assign bus.busy          = busy_q;
    assign bus.op_count      = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: requester drivers push expected results,
// a negedge monitor predicts grants/latency and checks every response against them.
module tb_alu_share_arbiter;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;

    alu_share_arbiter_if #(.CNT_W(CNT_W)) bus ();

    alu_share_arbiter #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] res;
        logic        cpc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   grant_log[$];
    int   checks      = 0;
    int   failures    = 0;
    int   cycle       = 0;
    int   pending     = -1;
    int   acc_cycle   = 0;
    int   last_served = 1;
    int   exp_count   = 0;
    int   rr_mode     = 0;
    bit   mon_en      = 1'b0;
    bit   m_ra, m_rb, m_av, m_bv;
    exp_t m_e;

    // Reference ALU from the opcode table, using wide arithmetic reduced mod 2^32.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        longint unsigned lx, ly;
        lx = 64'(x);
        ly = 64'(y);
        e.op  = op;
        e.res = x;
        e.cpc = 1'b0;
        case (op)
            3'd2: e.cpc = (lx == ly);
            3'd3: e.cpc = (lx < ly);
            3'd4: e.res = 32'((lx + ly) % 64'h1_0000_0000);
            3'd5: e.res = 32'((lx + 64'h1_0000_0000 - ly) % 64'h1_0000_0000);
            3'd6: e.res = x & y;
            3'd7: e.res = x | y;
            default: e.res = x;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h time=%0t", name, got, exp, $time);
        end
    endtask

    // Monitor: predicts who may be granted, when the response shows, and its contents.
    always @(negedge clk) begin
        cycle++;
        if (mon_en && rst_n) begin
            m_ra = 1'b0;
            m_rb = 1'b0;
            if (pending < 0) begin
                if (bus.a_valid && bus.b_valid) begin
                    if (last_served == 0) m_rb = 1'b1;
                    else                  m_ra = 1'b1;
                end else if (bus.a_valid) begin
                    m_ra = 1'b1;
                end else if (bus.b_valid) begin
                    m_rb = 1'b1;
                end
            end
            check("a_ready", bus.a_ready, m_ra);
            check("b_ready", bus.b_ready, m_rb);
            check("busy", bus.busy, pending >= 0);
            check("op_count", bus.op_count, CNT_W'(exp_count));

            m_av = (pending == 0) && (cycle >= acc_cycle + 2);
            m_bv = (pending == 1) && (cycle >= acc_cycle + 2);
            check("a_rsp_valid", bus.a_rsp_valid, m_av);
            check("b_rsp_valid", bus.b_rsp_valid, m_bv);

            if (m_av || m_bv) begin
                m_e = m_av ? q_a[0] : q_b[0];
                if (m_e.op != 3'd2 && m_e.op != 3'd3)
                    check(m_av ? "a_result" : "b_result", bus.rsp_result, m_e.res);
                check(m_av ? "a_change_pc" : "b_change_pc", bus.rsp_change_pc, m_e.cpc);
                if (m_av ? bus.a_rsp_ready : bus.b_rsp_ready) begin
                    if (m_av) void'(q_a.pop_front());
                    else      void'(q_b.pop_front());
                    last_served = pending;
                    pending     = -1;
                    exp_count   = (exp_count + 1) % (1 << CNT_W);
                end
            end

            if (m_ra) begin
                q_a.push_back(model(bus.a_opcode, bus.a_in0, bus.a_in1));
                pending = 0; acc_cycle = cycle; grant_log.push_back(0);
            end else if (m_rb) begin
                q_b.push_back(model(bus.b_opcode, bus.b_in0, bus.b_in1));
                pending = 1; acc_cycle = cycle; grant_log.push_back(1);
            end
        end
    end

    // Response-ready driver: 0 = always ready, 1 = random, 2 = driven by the main sequence.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_mode == 0) begin
                bus.a_rsp_ready = 1'b1;
                bus.b_rsp_ready = 1'b1;
            end else if (rr_mode == 1) begin
                bus.a_rsp_ready = 1'($urandom % 2);
                bus.b_rsp_ready = 1'($urandom % 2);
            end
        end
    end

    // Present one operation, hold it until granted, then optionally wiggle the inputs.
    task automatic send(input int who, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input bit scramble);
        int n = 0;
        if (who == 0) begin
            bus.a_opcode = op; bus.a_in0 = x; bus.a_in1 = y; bus.a_valid = 1'b1;
        end else begin
            bus.b_opcode = op; bus.b_in0 = x; bus.b_in1 = y; bus.b_valid = 1'b1;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!((who == 0) ? bus.a_ready : bus.b_ready) && n < 300);
        check((who == 0) ? "a_grant_timeout" : "b_grant_timeout", n >= 300, 0);
        @(posedge clk);
        #1;
        if (who == 0) bus.a_valid = 1'b0;
        else          bus.b_valid = 1'b0;
        if (scramble) begin
            repeat (3) begin
                if (who == 0) begin
                    bus.a_in0 = $urandom; bus.a_in1 = $urandom; bus.a_opcode = 3'($urandom);
                end else begin
                    bus.b_in0 = $urandom; bus.b_in1 = $urandom; bus.b_opcode = 3'($urandom);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (pending >= 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", n >= 500, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        q_a.delete();
        q_b.delete();
        grant_log.delete();
        pending     = -1;
        last_served = 1;
        exp_count   = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        int n;
        rst_n = 1'b0;
        bus.a_valid = 1'b0; bus.a_opcode = '0; bus.a_in0 = '0; bus.a_in1 = '0;
        bus.b_valid = 1'b0; bus.b_opcode = '0; bus.b_in0 = '0; bus.b_in1 = '0;
        bus.a_rsp_ready = 1'b0; bus.b_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_a_rsp_valid", bus.a_rsp_valid, 0);
        check("rst_b_rsp_valid", bus.b_rsp_valid, 0);
        check("rst_result", bus.rsp_result, 0);
        check("rst_change_pc", bus.rsp_change_pc, 0);
        check("rst_op_count", bus.op_count, 0);
        #1;
        rst_n = 1'b1;
        clear_model();
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Single A add.
        send(0, 3'd4, 32'd5, 32'd7, 1'b0);
        wait_idle();
        check("op_count_after_first", bus.op_count, 1);

        // Tie between A and B, two operations each; winners must alternate.
        grant_log.delete();
        first = (last_served == 0) ? 1 : 0;
        fork
            begin send(0, 3'd5, 32'd10, 32'd3, 1'b0); send(0, 3'd5, 32'd10, 32'd3, 1'b0); end
            begin send(1, 3'd7, 32'hF0, 32'h0F, 1'b0); send(1, 3'd7, 32'hF0, 32'h0F, 1'b0); end
        join
        wait_idle();
        check("tie_grants", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size(); i++)
            check("tie_order", grant_log[i], (first + i) % 2);

        // Branch compares (unsigned blt) and 32-bit wrap on add.
        send(1, 3'd2, 32'd9, 32'd9, 1'b0);
        send(1, 3'd3, 32'hFFFF_FFFF, 32'd1, 1'b0);
        send(0, 3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_idle();

        // Owner back-pressure while B waits.
        rr_mode = 2;
        bus.a_rsp_ready = 1'b0;
        bus.b_rsp_ready = 1'b1;
        fork
            send(0, 3'd5, 32'd50, 32'd8, 1'b0);
            begin @(posedge clk); #1; send(1, 3'd4, 32'd1, 32'd2, 1'b0); end
            begin
                n = 0;
                while (!bus.a_rsp_valid && n < 50) begin @(negedge clk); n++; end
                check("hold_rsp_timeout", n >= 50, 0);
                repeat (5) @(posedge clk);
                #1;
                bus.a_rsp_ready = 1'b1;
            end
        join
        wait_idle();
        rr_mode = 0;

        // Inputs change after capture; pass-through opcode.
        send(0, 3'd4, 32'h10, 32'h20, 1'b1);
        send(0, 3'd1, 32'h1234, 32'h55, 1'b1);
        wait_idle();

        // Randomised traffic with random response back-pressure.
        rr_mode = 1;
        fork
            begin : rnd_a
                logic [31:0] x, y;
                repeat (50) begin
                    if ($urandom % 3 == 0) begin @(posedge clk); #1; end
                    x = $urandom;
                    y = ($urandom % 4 == 0) ? x : $urandom;
                    send(0, 3'($urandom), x, y, ($urandom % 4) == 0);
                end
            end
            begin : rnd_b
                logic [31:0] x, y;
                repeat (50) begin
                    if ($urandom % 3 == 0) begin @(posedge clk); #1; end
                    x = $urandom % 16;
                    y = ($urandom % 4 == 0) ? x : $urandom % 16;
                    send(1, 3'($urandom), x, y, ($urandom % 4) == 0);
                end
            end
        join
        rr_mode = 0;
        wait_idle();

        // Asynchronous reset while a response is waiting.
        rr_mode = 2;
        bus.a_rsp_ready = 1'b0;
        send(0, 3'd4, 32'd100, 32'd23, 1'b0);
        n = 0;
        while (!bus.a_rsp_valid && n < 50) begin @(negedge clk); n++; end
        check("reset_rsp_timeout", n >= 50, 0);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_busy", bus.busy, 0);
        check("async_a_rsp_valid", bus.a_rsp_valid, 0);
        check("async_result", bus.rsp_result, 0);
        check("async_change_pc", bus.rsp_change_pc, 0);
        check("async_op_count", bus.op_count, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_model();
        mon_en  = 1'b1;
        rr_mode = 0;
        @(posedge clk);
        #1;
        check("post_reset_op_count", bus.op_count, 0);

        // First tie after reset goes to A.
        fork
            send(0, 3'd6, 32'hFF00, 32'h0FF0, 1'b0);
            send(1, 3'd4, 32'd3, 32'd4, 1'b0);
        join
        wait_idle();
        check("post_reset_tie_count", grant_log.size(), 2);
        if (grant_log.size() > 0) check("post_reset_tie_first", grant_log[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
